mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data path width in bits.
REQ-002 Parameter ADDR_W, default 32, RAM address width in bits.
REQ-003 Parameter TIMEOUT, default 16, max cycles in WAIT before abort; 0 disables the timeout.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  block can accept an instruction.
REQ-008 op  in  5  opcode: 5'b11000 load, 5'b11001 store, op[4]==0 ALU, other op[4]==1 codes no-op.
REQ-009 addr  in  ADDR_W  load/store address.
REQ-010 data_alu  in  DATA_W  ALU result.
REQ-011 data_store  in  DATA_W  store data.
REQ-012 ram_req  out  1  RAM request.
REQ-013 ram_we  out  1  1 = write, 0 = read.
REQ-014 ram_addr  out  ADDR_W  RAM address.
REQ-015 ram_wdata  out  DATA_W  RAM write data.
REQ-016 ram_ack  in  1  RAM completion, one cycle; read data valid in the same cycle.
REQ-017 ram_rdata  in  DATA_W  RAM read data.
REQ-018 out_valid  out  1  one-cycle retire pulse.
REQ-019 reg_write  out  1  register write enable; qualified by out_valid.
REQ-020 data_reg  out  DATA_W  register write data.
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 States IDLE and WAIT only; in_ready = 1 in IDLE, 0 in WAIT.
REQ-023 Accept = in_valid && in_ready; inputs are sampled only on accept.
REQ-024 ALU accept: next cycle out_valid=1, reg_write=1, data_reg=data_alu; state stays IDLE; back-to-back ALU accepts give one retire per cycle.
REQ-025 No-op accept: next cycle out_valid=1, reg_write=0, data_reg holds; RAM untouched.
REQ-026 Load accept: register addr, drive ram_req=1, ram_we=0 from next cycle; go to WAIT.
REQ-027 Store accept: register addr and data_store, drive ram_req=1, ram_we=1 from next cycle; go to WAIT.
REQ-028 In WAIT: ram_req, ram_we, ram_addr and ram_wdata are held stable until the cycle ram_ack is sampled high.
REQ-029 ram_ack in WAIT, load: next cycle out_valid=1, reg_write=1, data_reg=ram_rdata captured on the ack edge; ram_req=0; go to IDLE.
REQ-030 ram_ack in WAIT, store: next cycle out_valid=1, reg_write=0; ram_req=0; go to IDLE.
REQ-031 Minimum load/store latency: accept at edge N, ram_req high N+1, ack at N+1, retire at N+2; next accept possible at N+2.
REQ-032 Wait counter clears on entering WAIT and increments each WAIT cycle without ack; counter width is clog2(TIMEOUT+1).
REQ-033 TIMEOUT>0 and counter reaches TIMEOUT without ack: ram_req=0; next cycle out_valid=1, reg_write=0; err set; go to IDLE.
REQ-034 Ack in the same cycle the counter reaches TIMEOUT: the ack wins; no err.
REQ-035 ram_ack in IDLE is ignored.
REQ-036 err stays set until rst; the block keeps operating while err=1.
REQ-037 out_valid and reg_write are 0 on every cycle that is not a retire; data_reg changes only on reg_write retires.

Reset
REQ-038 rst=1 forces IDLE and clears the counter, ram_req, ram_we, out_valid, reg_write and err; ram_addr, ram_wdata and data_reg become 0.
REQ-039 rst asserted in WAIT aborts the RAM request immediately (ram_req=0) and produces no retire.
REQ-040 After rst is released, in_ready=1 from the first clk edge.

Verification
REQ-041 ALU op=0, data_alu=0x1234 on three consecutive cycles -> three consecutive out_valid pulses, reg_write=1, data_reg=0x1234.
REQ-042 Load addr=0x40, ack after 3 wait cycles with rdata=0xDEADBEEF -> ram_req high 3 cycles, then one retire with reg_write=1, data_reg=0xDEADBEEF; in_ready=0 throughout.
REQ-043 Store addr=0x80, data_store=0xA5A5A5A5, ack on the first request cycle -> ram_we=1, ram_wdata=0xA5A5A5A5 during request; retire with reg_write=0; data_reg unchanged.
REQ-044 TIMEOUT=4, load with no ack -> ram_req drops after 4 cycles, retire with reg_write=0, err=1 until rst.
REQ-045 rst pulsed during WAIT -> ram_req=0 asynchronously, no out_valid, in_ready=1 after release.
REQ-046 op=5'b11111 accepted -> retire with reg_write=0, ram_req never asserted.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage controller. It accepts one instruction at a time
//               and handles each one by its opcode:
//               - ALU and no-op instructions retire on the next cycle.
//               - Loads and stores issue a single RAM request and wait for
//                 ram_ack, with an optional timeout abort.
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid/in_ready   - upstream instruction handshake
//               op, addr            - opcode and load/store address
//               data_alu/data_store - ALU result / store data
//               ram_*               - single-outstanding RAM request port
//               out_valid/reg_write/data_reg - one-cycle retire outputs
//               err                 - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_alu,
    input  logic [DATA_W-1:0] data_store,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    output logic              reg_write,
    output logic [DATA_W-1:0] data_reg,
    output logic              err
);

    localparam logic [4:0] c_op_load  = 5'b11000;
    localparam logic [4:0] c_op_store = 5'b11001;

    // The counter is kept at least 1 bit wide, so a disabled timeout
    // (TIMEOUT=0) still builds cleanly.
    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // The abort is taken on the un-acked cycle that would advance the counter
    // to TIMEOUT, so ram_req is high for exactly TIMEOUT cycles.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t               r_state,   w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,     w_cnt_nxt;
    logic                 w_req_nxt, w_we_nxt, w_ov_nxt, w_rw_nxt, w_err_nxt;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [DATA_W-1:0]    w_wdata_nxt, w_dreg_nxt;

    assign in_ready = (r_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            out_valid <= 1'b0;
            reg_write <= 1'b0;
            data_reg  <= '0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            ram_req   <= w_req_nxt;
            ram_we    <= w_we_nxt;
            ram_addr  <= w_addr_nxt;
            ram_wdata <= w_wdata_nxt;
            out_valid <= w_ov_nxt;
            reg_write <= w_rw_nxt;
            data_reg  <= w_dreg_nxt;
            err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = ram_req;
        w_we_nxt    = ram_we;
        w_addr_nxt  = ram_addr;
        w_wdata_nxt = ram_wdata;
        w_ov_nxt    = 1'b0;
        w_rw_nxt    = 1'b0;
        w_dreg_nxt  = data_reg;
        w_err_nxt   = err;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (op == c_op_load || op == c_op_store) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = (op == c_op_store);
                        w_addr_nxt  = addr;
                        if (op == c_op_store) begin
                            w_wdata_nxt = data_store;
                        end
                    end else if (!op[4]) begin
                        w_ov_nxt   = 1'b1;
                        w_rw_nxt   = 1'b1;
                        w_dreg_nxt = data_alu;
                    end else begin
                        w_ov_nxt = 1'b1;
                    end
                end
            end
            WAIT: begin
                // ram_we still records whether the request is a load or a store.
                if (ram_ack) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_ov_nxt    = 1'b1;
                    w_rw_nxt    = !ram_we;
                    if (!ram_we) begin
                        w_dreg_nxt = ram_rdata;
                    end
                end else if (TIMEOUT > 0 && r_cnt == c_cnt_last) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_ov_nxt    = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Randomized self-checking bench for mem_stage_ctrl.
//               A transaction-level reference model tracks the pending RAM
//               operation, the retire outputs, data_reg and err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_alu, data_store;
    logic              ram_req, ram_we, ram_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              out_valid, reg_write, err;
    logic [DATA_W-1:0] data_reg;

    mem_stage_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .addr(addr),
        .data_alu(data_alu), .data_store(data_store),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .reg_write(reg_write), .data_reg(data_reg), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one outstanding memory transaction plus architectural results.
    bit                m_busy, m_store, m_ov, m_rw, m_err;
    int                m_waited;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_dreg;

    task automatic model_reset();
        m_busy = 0; m_store = 0; m_ov = 0; m_rw = 0; m_err = 0;
        m_waited = 0; m_addr = '0; m_wdata = '0; m_dreg = '0;
    endtask

    // Applies one rising edge worth of spec rules to the model.
    task automatic model_edge();
        m_ov = 0;
        m_rw = 0;
        if (!m_busy) begin
            if (in_valid) begin
                if (op == 5'b11000 || op == 5'b11001) begin
                    m_busy   = 1;
                    m_store  = (op == 5'b11001);
                    m_addr   = addr;
                    m_waited = 0;
                    if (m_store) m_wdata = data_store;
                end else begin
                    m_ov = 1;
                    if (op[4] == 1'b0) begin
                        m_rw   = 1;
                        m_dreg = data_alu;
                    end
                end
            end
        end else if (ram_ack) begin
            m_busy = 0;
            m_ov   = 1;
            m_rw   = !m_store;
            if (!m_store) m_dreg = ram_rdata;
        end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
                m_busy = 0;
                m_ov   = 1;
                m_err  = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("in_ready",  64'(in_ready),  64'(!m_busy));
        check_val("ram_req",   64'(ram_req),   64'(m_busy));
        check_val("out_valid", 64'(out_valid), 64'(m_ov));
        check_val("reg_write", 64'(reg_write), 64'(m_rw));
        check_val("data_reg",  64'(data_reg),  64'(m_dreg));
        check_val("err",       64'(err),       64'(m_err));
        if (m_busy) begin
            check_val("ram_we",   64'(ram_we),   64'(m_store));
            check_val("ram_addr", 64'(ram_addr), 64'(m_addr));
            if (m_store) check_val("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
        end
    endtask

    task automatic drive_random();
        int kind;
        kind       = $urandom_range(0, 3);
        in_valid   = ($urandom_range(0, 3) != 0);
        case (kind)
            0:       op = 5'b11000;
            1:       op = 5'b11001;
            2:       op = {1'b0, 4'($urandom_range(0, 15))};
            default: op = {1'b1, 4'($urandom_range(0, 15))};
        endcase
        addr       = $urandom;
        data_alu   = $urandom;
        data_store = $urandom;
        ram_rdata  = $urandom;
        ram_ack    = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; op = '0; addr = '0; data_alu = '0;
        data_store = '0; ram_ack = 0; ram_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_val("rst_ram_addr",  64'(ram_addr),  64'h0);
        check_val("rst_ram_wdata", 64'(ram_wdata), 64'h0);
        rst = 1'b0;
        drive_random();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            drive_random();
        end

        // Put a load in flight, then reset asynchronously while waiting.
        in_valid = 1; op = 5'b11000; addr = 32'h40; ram_ack = 0;
        begin
            int guard = 0;
            while (!m_busy && guard < 20) begin
                @(posedge clk); model_edge(); @(negedge clk); check_outputs();
                guard++;
            end
        end
        in_valid = 0; ram_ack = 0;
        @(posedge clk); model_edge(); @(negedge clk); check_outputs();
        check_val("pre_rst_busy", 64'(ram_req), 64'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("async_rst_ram_req",   64'(ram_req),   64'h0);
        check_val("async_rst_in_ready",  64'(in_ready),  64'h1);
        check_val("async_rst_out_valid", 64'(out_valid), 64'h0);
        check_val("async_rst_err",       64'(err),       64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk); model_edge(); @(negedge clk); check_outputs();
        end

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
